// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one registered WIDTH-bit adder between two requesters.
// Issue slots come from a free-running clock-enable divider; results leave via a one-entry buffer.
module adder_share_arbiter #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned DIV   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] op0_a,
   input  logic [WIDTH-1:0] op0_b,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] op1_a,
   input  logic [WIDTH-1:0] op1_b,
   output logic             gnt1,
   output logic             res_valid,
   output logic [WIDTH:0]   res_data,
   output logic             res_id,
   input  logic             res_ready,
   output logic             busy
);

   localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   typedef enum logic {StEmpty, StFull} buf_state_e;

   buf_state_e       state_q, state_d;
   logic [CntW-1:0]  div_cnt_q, div_cnt_d;
   logic [WIDTH:0]   res_data_q, res_data_d;
   logic             res_id_q, res_id_d;
   logic             last_gnt_q, last_gnt_d;
   logic             slot, can_issue, pick1, gnt0_c, gnt1_c;
   logic [WIDTH-1:0] win_a, win_b;

   always_comb begin
      slot      = (div_cnt_q == CntMax);
      div_cnt_d = slot ? '0 : div_cnt_q + CntW'(1);
      can_issue = slot & ((state_q == StEmpty) | res_ready);
      // Requester 1 wins when alone, or on a tie when requester 0 won last.
      pick1     = req1 & (~req0 | ~last_gnt_q);
      // Gating with rst_n keeps grants low throughout reset, even when DIV=1.
      gnt0_c    = rst_n & can_issue & req0 & ~pick1;
      gnt1_c    = rst_n & can_issue & pick1;
      win_a     = pick1 ? op1_a : op0_a;
      win_b     = pick1 ? op1_b : op0_b;

      state_d    = state_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      last_gnt_d = last_gnt_q;
      if (gnt0_c | gnt1_c) begin
         state_d    = StFull;
         res_data_d = {1'b0, win_a} + {1'b0, win_b};
         res_id_d   = gnt1_c;
         last_gnt_d = gnt1_c;
      end else if ((state_q == StFull) && res_ready) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         div_cnt_q  <= '0;
         res_data_q <= '0;
         res_id_q   <= 1'b0;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   assign gnt0      = gnt0_c;
   assign gnt1      = gnt1_c;
   assign res_valid = (state_q == StFull);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign busy      = res_valid | req0 | req1;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: a DIV=2 and a DIV=1 instance share stimulus and are
// each tracked by a cycle-level reference model, plus directed scenario checks.
module tb_adder_share_arbiter;

   localparam int W = 7;

   logic clk = 1'b0;
   logic rst_n;
   logic req0, req1, res_ready;
   logic [W-1:0] op0_a, op0_b, op1_a, op1_b;

   logic [1:0]      gnt0_w, gnt1_w, valid_w, id_w, busy_w;
   logic [1:0][W:0] data_w;

   int errors = 0;
   int checks = 0;

   // Model state per instance: index 0 is DIV=2, index 1 is DIV=1.
   int   div_of [2] = '{2, 1};
   int   m_n    [2];
   logic m_valid[2];
   int   m_data [2];
   int   m_id   [2];
   int   m_last [2];
   int   pend_g [2];

   always #5 clk = ~clk;

   adder_share_arbiter #(.WIDTH(W), .DIV(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .op0_a(op0_a), .op0_b(op0_b), .gnt0(gnt0_w[0]),
      .req1(req1), .op1_a(op1_a), .op1_b(op1_b), .gnt1(gnt1_w[0]),
      .res_valid(valid_w[0]), .res_data(data_w[0]), .res_id(id_w[0]),
      .res_ready(res_ready), .busy(busy_w[0])
   );

   adder_share_arbiter #(.WIDTH(W), .DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .op0_a(op0_a), .op0_b(op0_b), .gnt0(gnt0_w[1]),
      .req1(req1), .op1_a(op1_a), .op1_b(op1_b), .gnt1(gnt1_w[1]),
      .res_valid(valid_w[1]), .res_data(data_w[1]), .res_id(id_w[1]),
      .res_ready(res_ready), .busy(busy_w[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_n[k] = 0; m_valid[k] = 1'b0; m_data[k] = 0; m_id[k] = 0; m_last[k] = 1;
         pend_g[k] = -1;
      end
   endtask

   // Winner of this cycle's contest for instance k, -1 when nobody is granted.
   function automatic int winner(input int k);
      bit slot_ok, can;
      if (!rst_n) return -1;
      slot_ok = (m_n[k] % div_of[k]) == (div_of[k] - 1);
      can     = slot_ok && (!m_valid[k] || res_ready);
      if (!can) return -1;
      if (req0 && req1) return (m_last[k] == 0) ? 1 : 0;
      if (req0) return 0;
      if (req1) return 1;
      return -1;
   endfunction

   task automatic cycle();
      #1;
      for (int k = 0; k < 2; k++) begin
         pend_g[k] = winner(k);
         chk($sformatf("gnt0[%0d]", k), 32'(gnt0_w[k]), 32'(pend_g[k] == 0));
         chk($sformatf("gnt1[%0d]", k), 32'(gnt1_w[k]), 32'(pend_g[k] == 1));
         chk($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(m_valid[k] | req0 | req1));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_n[k] = 0; m_valid[k] = 1'b0; m_data[k] = 0; m_id[k] = 0; m_last[k] = 1;
         end else begin
            if (pend_g[k] == 0) begin
               m_valid[k] = 1'b1; m_data[k] = int'(op0_a) + int'(op0_b);
               m_id[k] = 0; m_last[k] = 0;
            end else if (pend_g[k] == 1) begin
               m_valid[k] = 1'b1; m_data[k] = int'(op1_a) + int'(op1_b);
               m_id[k] = 1; m_last[k] = 1;
            end else if (m_valid[k] && res_ready) begin
               m_valid[k] = 1'b0;
            end
            m_n[k]++;
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("res_valid[%0d]", k), 32'(valid_w[k]), 32'(m_valid[k]));
         chk($sformatf("res_data[%0d]", k), 32'(data_w[k]), 32'(m_data[k]));
         chk($sformatf("res_id[%0d]", k), 32'(id_w[k]), 32'(m_id[k]));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      int got, n2, n1;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
      op0_a = '0; op0_b = '0; op1_a = '0; op1_b = '0;
      model_reset();
      #12;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_valid[%0d]", k), 32'(valid_w[k]), 32'd0);
         chk($sformatf("rst_data[%0d]", k), 32'(data_w[k]), 32'd0);
         chk($sformatf("rst_id[%0d]", k), 32'(id_w[k]), 32'd0);
         chk($sformatf("rst_gnt[%0d]", k), 32'(gnt0_w[k] | gnt1_w[k]), 32'd0);
      end
      rst_n = 1'b1;

      // Single requester: 100 + 27.
      req0 = 1'b1; op0_a = 7'd100; op0_b = 7'd27; res_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
         cycle();
         if (pend_g[0] == 0) got = 1;
      end
      chk("t1_granted", 32'(got), 32'd1);
      chk("t1_data", 32'(data_w[0]), 32'd127);
      chk("t1_id", 32'(id_w[0]), 32'd0);
      req0 = 1'b0;
      cycle();
      cycle();
      chk("t1_busy_low", 32'(busy_w[0]), 32'd0);

      // Both requesting continuously: alternating 0,1,0,1.
      do_reset();
      req0 = 1'b1; req1 = 1'b1; res_ready = 1'b1;
      op0_a = 7'd1; op0_b = 7'd2; op1_a = 7'd5; op1_b = 7'd6;
      n2 = 0; n1 = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (pend_g[0] >= 0) begin
            chk("t2_id_div2", 32'(id_w[0]), 32'(n2 % 2));
            chk("t2_data_div2", 32'(data_w[0]), (n2 % 2) ? 32'd11 : 32'd3);
            n2++;
         end
         if (pend_g[1] >= 0) begin
            chk("t2_id_div1", 32'(id_w[1]), 32'(n1 % 2));
            chk("t2_data_div1", 32'(data_w[1]), (n1 % 2) ? 32'd11 : 32'd3);
            n1++;
         end
      end
      chk("t2_rate_div2", 32'(n2), 32'd4);
      chk("t2_rate_div1", 32'(n1), 32'd8);

      // Maximum operands must not wrap.
      req1 = 1'b0; req0 = 1'b1; op0_a = 7'd127; op0_b = 7'd127;
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
         cycle();
         if (pend_g[0] == 0) got = 1;
      end
      chk("t3_granted", 32'(got), 32'd1);
      chk("t3_data", 32'(data_w[0]), 32'd254);
      req0 = 1'b0;
      cycle();

      // Backpressure: stall with both pending, then release on a slot edge.
      do_reset();
      res_ready = 1'b0; req0 = 1'b1; req1 = 1'b1;
      op0_a = 7'd1; op0_b = 7'd2; op1_a = 7'd5; op1_b = 7'd6;
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
         cycle();
         if (pend_g[0] == 0) got = 1;
      end
      chk("t4_first", 32'(got), 32'd1);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("t4_no_gnt", 32'(gnt0_w[0] | gnt1_w[0]), 32'd0);
         cycle();
         chk("t4_hold_data", 32'(data_w[0]), 32'd3);
         chk("t4_hold_valid", 32'(valid_w[0]), 32'd1);
      end
      for (int i = 0; i < 4 && (m_n[0] % 2) != 1; i++) cycle();
      res_ready = 1'b1;
      cycle();
      chk("t4_no_bubble", 32'(valid_w[0]), 32'd1);
      chk("t4_next_data", 32'(data_w[0]), 32'd11);
      chk("t4_next_id", 32'(id_w[0]), 32'd1);

      // Asynchronous reset while FULL.
      res_ready = 1'b0;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("t5_valid[%0d]", k), 32'(valid_w[k]), 32'd0);
         chk($sformatf("t5_data[%0d]", k), 32'(data_w[k]), 32'd0);
         chk($sformatf("t5_gnt[%0d]", k), 32'(gnt0_w[k] | gnt1_w[k]), 32'd0);
      end
      model_reset();
      cycle();
      #2;
      rst_n = 1'b1;
      res_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
         cycle();
         if (pend_g[0] >= 0) got = 1;
      end
      chk("t5_regranted", 32'(got), 32'd1);
      chk("t5_first_id", 32'(id_w[0]), 32'd0);

      // Short req1 pulse off a slot edge.
      req0 = 1'b0; req1 = 1'b0;
      do_reset();
      req1 = 1'b1;
      #1;
      chk("t6_no_gnt1", 32'(gnt1_w[0]), 32'd0);
      cycle();
      req1 = 1'b0;
      cycle();
      cycle();
      chk("t6_valid_low", 32'(valid_w[0]), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         res_ready = ($urandom_range(0, 3) != 0);
         op0_a = W'($urandom); op0_b = W'($urandom);
         op1_a = W'($urandom); op1_b = W'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
